reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
Consumer end of the system reset-request path. It accepts single-cycle or level reset requests, for example from the periodic auto-reset generator or a debug trigger. It then drives a staged reset: all domains are held, peripherals/interconnect are released first, and cores are released after a stagger. A cooldown window follows, during which one further request is queued rather than lost. It sits between the request sources and the reset inputs of the cache test system.

Parameters:
HOLD_CYCLES, 16, cycles both reset outputs stay asserted before the peripheral release
STAGGER_CYCLES, 8, cycles between the peripheral release and the core release
COOLDOWN_CYCLES, 32, cycles after the core release during which new requests are queued, not started
CNT_WIDTH, 8, timer width; every *_CYCLES value must be >=1 and <2**CNT_WIDTH

Ports:
clk_i  in  1  system clock; all logic on the rising edge
rst_i  in  1  synchronous active-high reset
en_i  in  1  request acceptance enable, sampled only in IDLE
rst_req_i  in  1  reset request, level or pulse, sampled every cycle
rst_periph_o  out  1  registered active-high reset for peripherals/interconnect
rst_core_o  out  1  registered active-high reset for cores
busy_o  out  1  high whenever state != IDLE
done_o  out  1  one-cycle pulse in the first cycle rst_core_o is low
merged_o  out  1  one-cycle pulse when a request is absorbed in ASSERT or REL_PERIPH
req_count_o  out  8  saturating count of request-initiated sequences

Behaviour:
- One clock, clk_i. Reset rst_i is synchronous and active-high.
- rst_i high at an edge: state=ASSERT, timer=0, pending=0, req_count_o=0. Outputs after that edge: rst_periph_o=1, rst_core_o=1, busy_o=1, done_o=0, merged_o=0.
- While rst_i stays high, the timer holds at 0. HOLD counting starts in the first cycle rst_i is low. This gives a power-on sequence without any request.
- States:
  - IDLE: both resets low.
  - ASSERT: both resets high.
  - REL_PERIPH: periph low, core high.
  - COOLDOWN: both low.
- Each timed state lasts exactly its parameter's number of cycles. The timer loads 0 on state entry and the state exits when timer == N-1.
- IDLE -> ASSERT when rst_req_i=1 and en_i=1 in cycle k. Both resets are high from cycle k+1, and req_count_o increments (saturates at 255).
- Timing relative to cycle k:
  - rst_periph_o low from k+1+HOLD.
  - rst_core_o low from k+1+HOLD+STAGGER; done_o is high in that cycle only.
  - COOLDOWN occupies k+1+HOLD+STAGGER .. k+HOLD+STAGGER+COOLDOWN.
- Requests in ASSERT or REL_PERIPH are merged into the running sequence. merged_o pulses the following cycle, the count is unchanged and no pending request is recorded. A level request held through the sequence pulses merged_o every cycle it is seen there.
- Requests in COOLDOWN set pending, regardless of en_i. At the end of COOLDOWN:
  - pending=1: go directly to ASSERT, clear pending, increment the count. Resets are high in the cycle that would otherwise be IDLE.
  - pending=0: go to IDLE.
- Request with en_i=0 in IDLE: ignored, no state change.
- en_i deassertion never aborts a sequence in progress.
- A request held high continuously restarts a sequence after every cooldown. This is intended.
- rst_i mid-sequence overrides everything: ASSERT on the next edge with pending and count cleared.
- No combinational path from any input to any output.

Decomposition:
- Package reset_seq_pkg:
  - state enum {IDLE, ASSERT, REL_PERIPH, COOLDOWN}, 2-bit encoding;
  - COUNT_W=8;
  - COUNT_MAX=255.
- One natural sub-module, reset_seq_timer: CNT_WIDTH up-counter with synchronous clear and a terminal-compare input, reused by all three timed states.

Test Plan:
All scenarios use HOLD=4, STAGGER=2, COOLDOWN=6.
1. Power-on: rst_i high for cycles 0-2, low from cycle 3 -> periph low at 7, core low at 9, done_o=1 at 9 only, busy_o low at 15, req_count_o=0.
2. In IDLE, rst_req_i pulse at cycle 20 with en_i=1 -> resets high at 21, periph low at 25, core low and done_o at 27, IDLE at 33, req_count_o=1.
3. Pulse during COOLDOWN at cycle 30 -> no immediate change; resets high at 33 with no IDLE cycle; req_count_o=2; second done_o at 39.
4. Pulse during ASSERT at cycle 23 -> merged_o=1 at 24, timing unchanged from scenario 2, count unchanged.
5. en_i=0 with an IDLE request -> no output change and count unchanged. Then en_i=0 after a sequence starts -> the sequence completes normally.
6. rst_i pulse during REL_PERIPH while pending=0, and separately during COOLDOWN with pending=1 -> both resets high on the next edge, count=0, pending cleared, fresh HOLD counted from rst_i release.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ASSERT     = 2'd1,
        REL_PERIPH = 2'd2,
        COOLDOWN   = 2'd3
    } state_t;

    localparam int COUNT_W = 8;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 8'd255;

endpackage

// File: rtl/reset_seq_timer.sv
// Up-counter with synchronous clear and terminal compare,
// shared by all timed sequencer states.
module reset_seq_timer #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 clr_i,
    input  logic [CNT_WIDTH-1:0] term_i,
    output logic                 hit_o
);

    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset driver: hold both domains, release peripherals,
// then cores, then a cooldown that queues one further request.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGGER_CYCLES  = 8,
    parameter int COOLDOWN_CYCLES = 32,
    parameter int CNT_WIDTH       = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               rst_req_i,
    output logic               rst_periph_o,
    output logic               rst_core_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               merged_o,
    output logic [COUNT_W-1:0] req_count_o
);

    state_t               state_q;
    state_t               state_d;
    logic                 pend_q;
    logic                 pend_d;
    logic                 cnt_inc;
    logic                 merge_d;
    logic                 done_d;
    logic                 hit;
    logic                 tmr_clr;
    logic [CNT_WIDTH-1:0] term;

    always_comb begin
        term = '0;
        unique case (state_q)
            ASSERT:     term = CNT_WIDTH'(HOLD_CYCLES - 1);
            REL_PERIPH: term = CNT_WIDTH'(STAGGER_CYCLES - 1);
            COOLDOWN:   term = CNT_WIDTH'(COOLDOWN_CYCLES - 1);
            default:    term = '0;
        endcase
    end

    // Timer restarts from zero on every state entry.
    assign tmr_clr = rst_i
                   | (state_d != state_q)
                   | (state_q == IDLE);

    reset_seq_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .clk_i  (clk_i),
        .clr_i  (tmr_clr),
        .term_i (term),
        .hit_o  (hit)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_inc = 1'b0;
        merge_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rst_req_i && en_i) begin
                    state_d = ASSERT;
                    cnt_inc = 1'b1;
                end
            end
            ASSERT: begin
                merge_d = rst_req_i;
                if (hit) begin
                    state_d = REL_PERIPH;
                end
            end
            REL_PERIPH: begin
                merge_d = rst_req_i;
                if (hit) begin
                    state_d = COOLDOWN;
                    done_d  = 1'b1;
                end
            end
            COOLDOWN: begin
                if (rst_req_i) begin
                    pend_d = 1'b1;
                end
                if (hit) begin
                    if (pend_d) begin
                        state_d = ASSERT;
                        pend_d  = 1'b0;
                        cnt_inc = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ASSERT;
            pend_q       <= 1'b0;
            req_count_o  <= '0;
            rst_periph_o <= 1'b1;
            rst_core_o   <= 1'b1;
            busy_o       <= 1'b1;
            done_o       <= 1'b0;
            merged_o     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            rst_periph_o <= (state_d == ASSERT);
            rst_core_o   <= (state_d == ASSERT)
                          | (state_d == REL_PERIPH);
            busy_o       <= (state_d != IDLE);
            done_o       <= done_d;
            merged_o     <= merge_d;
            if (cnt_inc && (req_count_o != COUNT_MAX)) begin
                req_count_o <= req_count_o + COUNT_W'(1);
            end
        end
    end

endmodule
